// File: rtl/jk_request_bank.sv
// Floor-call register: N JK cells with parallel load, preset-all and registered
// pending/lowest/highest status. Define DEBOUNCE_EN to add per-bit j/k stability filters.
module jk_request_bank #(
   parameter int N               = 8,
   parameter int JK11_MODE       = 0,
   parameter int IDXW            = $clog2(N),
   parameter int DEBOUNCE_CYCLES = 4
) (
   input  logic            clock,
   input  logic            reset,
   input  logic            enable,
   input  logic            preset_all,
   input  logic            load,
   input  logic [N-1:0]    load_value,
   input  logic [N-1:0]    j,
   input  logic [N-1:0]    k,
   output logic [N-1:0]    q,
   output logic            any_pending,
   output logic [IDXW-1:0] lowest_idx,
   output logic [IDXW-1:0] highest_idx
);

   logic [N-1:0]    jf, kf;
   logic [N-1:0]    q_q, q_d;
   logic            any_q, any_d;
   logic [IDXW-1:0] low_q, low_d;
   logic [IDXW-1:0] high_q, high_d;

`ifdef DEBOUNCE_EN
   // A filtered bit flips only after DEBOUNCE_CYCLES consecutive edges of disagreement.
   localparam logic [7:0] CNT_LAST = 8'(DEBOUNCE_CYCLES - 1);

   logic [N-1:0] jf_q, kf_q;

   for (genvar b = 0; b < N; b++) begin : g_filter
      logic [7:0] jcnt_q, kcnt_q;

      always_ff @(posedge clock or posedge reset) begin
         if (reset) begin
            jf_q[b] <= 1'b0;
            jcnt_q  <= 8'd0;
         end else if (j[b] != jf_q[b]) begin
            if (jcnt_q == CNT_LAST) begin
               jf_q[b] <= j[b];
               jcnt_q  <= 8'd0;
            end else begin
               jcnt_q  <= jcnt_q + 8'd1;
            end
         end else begin
            jcnt_q <= 8'd0;
         end
      end

      always_ff @(posedge clock or posedge reset) begin
         if (reset) begin
            kf_q[b] <= 1'b0;
            kcnt_q  <= 8'd0;
         end else if (k[b] != kf_q[b]) begin
            if (kcnt_q == CNT_LAST) begin
               kf_q[b] <= k[b];
               kcnt_q  <= 8'd0;
            end else begin
               kcnt_q  <= kcnt_q + 8'd1;
            end
         end else begin
            kcnt_q <= 8'd0;
         end
      end
   end

   assign jf = jf_q;
   assign kf = kf_q;
`else
   assign jf = j;
   assign kf = k;
`endif

   always_comb begin
      q_d = q_q;
      if (load) begin
         q_d = load_value;
      end else if (preset_all) begin
         q_d = '1;
      end else if (enable) begin
         for (int i = 0; i < N; i++) begin
            case ({jf[i], kf[i]})
               2'b01:   q_d[i] = 1'b0;
               2'b10:   q_d[i] = 1'b1;
               2'b11: begin
                  if (JK11_MODE == 1)      q_d[i] = 1'b1;
                  else if (JK11_MODE == 2) q_d[i] = 1'b0;
                  else                     q_d[i] = ~q_q[i];
               end
               default: q_d[i] = q_q[i];
            endcase
         end
      end
   end

   // Status is derived from q_d so it lands on the same edge as q.
   always_comb begin
      any_d  = |q_d;
      low_d  = '0;
      high_d = '0;
      for (int i = N - 1; i >= 0; i--) begin
         if (q_d[i]) low_d = IDXW'(i);
      end
      for (int i = 0; i < N; i++) begin
         if (q_d[i]) high_d = IDXW'(i);
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         q_q    <= '0;
         any_q  <= 1'b0;
         low_q  <= '0;
         high_q <= '0;
      end else begin
         q_q    <= q_d;
         any_q  <= any_d;
         low_q  <= low_d;
         high_q <= high_d;
      end
   end

   assign q           = q_q;
   assign any_pending = any_q;
   assign lowest_idx  = low_q;
   assign highest_idx = high_q;

endmodule

// File: doc/jk_request_bank.md
Name: jk_request_bank

Overview:
- Parametrised bank of N JK storage cells, used as the elevator's floor-call register.
- Per channel: J sets (latches) a call, K clears it on arrival, J+K follows a selectable mode.
- Adds a synchronous parallel load, a synchronous preset-all, and registered status outputs (any pending, lowest/highest pending index) for the floor scheduler.
- Sits between the button/sensor front end and the direction/scheduling FSM.

Parameters:
- N, 8, number of channels (floors); legal range 2..32.
- JK11_MODE, 0, effect of J=K=1: 0 = toggle, 1 = set-dominant, 2 = clear-dominant.
- IDXW, $clog2(N), width of the index outputs.
- DEBOUNCE_CYCLES, 4, filter length; used only when DEBOUNCE_EN is defined; legal range 2..255.

Ports:
- clock  input  1  rising-edge clock
- reset  input  1  asynchronous, active-high; clears all state
- enable  input  1  when 0, JK action is suppressed; load and preset_all still act
- preset_all  input  1  synchronous; sets every q bit to 1
- load  input  1  synchronous parallel load of load_value
- load_value  input  N  value written by load
- j  input  N  per-channel set request
- k  input  N  per-channel clear request
- q  output  N  channel state, registered
- any_pending  output  1  OR of q, registered
- lowest_idx  output  IDXW  index of the lowest set q bit, registered
- highest_idx  output  IDXW  index of the highest set q bit, registered

Behaviour:
- Reset: reset, asynchronous, active-high; clock clock.
  - While reset=1: q=0, any_pending=0, lowest_idx=0, highest_idx=0.
  - With DEBOUNCE_EN, the filter state is also cleared: filtered j/k = 0, counters = 0.
  - Deassertion is not synchronised here; the deassertion edge is assumed synchronised upstream.
- Next state q_n is evaluated at each rising edge in this priority order:
  - load=1: q_n = load_value.
  - else preset_all=1: q_n = all ones.
  - else enable=0: q_n = q.
  - else, per bit i, on {jf[i],kf[i]}:
    - 00: hold.
    - 01: clear.
    - 10: set.
    - 11: per JK11_MODE; toggle (~q[i]), set (1) or clear (0).
  - jf/kf are j/k directly, or the filtered values when DEBOUNCE_EN is defined.
- Latency: one clock from input to q when no filter is present.
- Status outputs:
  - Computed from q_n and registered on the same edge as q, so they are always consistent with the current q; no extra cycle of latency.
  - With no bit set: any_pending=0, lowest_idx=0, highest_idx=0.
  - With a single bit set: lowest_idx = highest_idx = that index.
- Boundary conditions:
  - A clear (K) and set (J) on different channels in the same cycle are independent.
  - load overrides all j/k activity that cycle.
  - Reset asserted mid-cycle clears immediately, without waiting for a clock edge.
  - Toggle mode with J=K=1 held: q[i] alternates every enabled edge.
  - Unused index codes (N not a power of 2) never appear on the index outputs.
- No internal FSM other than the per-bit cells and the filter counters. All outputs are driven from flops.

Optional Feature:
- Macro: DEBOUNCE_EN.
- Defined: each j and k bit has a stability filter.
  - Filtered value jf[i] takes the raw value at the DEBOUNCE_CYCLES-th consecutive rising edge at which raw differs from jf[i].
  - Any edge with raw equal to jf[i] resets that bit's counter to 0.
  - The filter runs every clock, independent of enable, load and preset_all.
  - Raw-to-q latency is DEBOUNCE_CYCLES+1 edges.
  - A raw pulse shorter than DEBOUNCE_CYCLES edges has no effect.
- Undefined: jf=j and kf=k; no counters exist; latency is 1 edge.

Test Plan:
- Reset async: set q=8'hA5 via load, assert reset between edges -> q=0, any_pending=0 and both indices 0 immediately, before the next edge.
- JK table: N=8, mode 0; on successive edges j=8'h01 -> q=01; k=8'h01 -> q=00; j=k=8'h81 held 3 edges -> q=81, 00, 81. Repeat with mode 1 (q stays 81) and mode 2 (q stays 00).
- Priority: load=1, load_value=8'h3C, preset_all=1, j=8'hFF -> q=3C. Then load=0, preset_all=1, k=8'hFF -> q=FF. Then enable=0, k=8'hFF -> q holds FF.
- Status: q=8'h24 -> any_pending=1, lowest_idx=2, highest_idx=5, on the same edge q updates. q=8'h80 -> both indices 7. q=0 -> all status outputs 0.
- Debounce (DEBOUNCE_EN, DEBOUNCE_CYCLES=4):
  - j[3] high for 3 edges then low -> q unchanged.
  - j[3] high for 4 edges -> q[3]=1 at the 5th edge.
  - k[3] glitch of 1 edge -> q[3] stays 1.
- Independence: j=8'h10 and k=8'h02 with q=8'h02 -> q=8'h10, lowest_idx=4, highest_idx=4.
